// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register and write-side driver of the register file.
//
// Captures the memory stage result (register write, HI/LO write, LLbit write)
// and presents it one cycle later to the regfile write port, HI/LO unit and
// LLbit unit. Applies the stall/flush bubble policy and counts retired
// register-file writes to nonzero addresses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        per-stage stop vector (bit 4 = MEM held, bit 5 = WB held)
//   flush             exception flush, replaces the MEM result with a bubble
//   mem_*             memory-stage result inputs
//   wb_*              registered outputs to regfile / HI/LO / LLbit units
//   wb_valid          registered slot holds a real instruction
//   retired_cnt       modulo-2^CNT_W count of completed nonzero-address writes
module mem_wb #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic [4:0]       mem_wd,
    input  logic             mem_wreg,
    input  logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_hi,
    input  logic [31:0]      mem_lo,
    input  logic             mem_whilo,
    input  logic             mem_LLbit_we,
    input  logic             mem_LLbit_value,
    output logic [4:0]       wb_wd,
    output logic             wb_wreg,
    output logic [31:0]      wb_wdata,
    output logic [31:0]      wb_hi,
    output logic [31:0]      wb_lo,
    output logic             wb_whilo,
    output logic             wb_LLbit_we,
    output logic             wb_LLbit_value,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        llbit_we;
        logic        llbit_value;
        logic        valid;
    } slot_t;

    slot_t            slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;
    logic             slot_retires;

    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;

        // MEM held while WB runs would replay the held instruction next
        // cycle, so that case is bubbled just like a flush.
        bubble = flush || (stall[4] && !stall[5]);

        // The outgoing slot is committed at this edge unless WB is held;
        // address 0 writes reach the regfile but are not real retirements.
        slot_retires = slot_q.valid && slot_q.wreg && (slot_q.wd != 5'd0) && !stall[5];
        if (slot_retires) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (bubble) begin
            slot_d = '0;
        end else if (!stall[4]) begin
            // stall[4]=0 with stall[5]=1 is an illegal encoding; it captures.
            slot_d.wd          = mem_wd;
            slot_d.wreg        = mem_wreg;
            slot_d.wdata       = mem_wdata;
            slot_d.hi          = mem_hi;
            slot_d.lo          = mem_lo;
            slot_d.whilo       = mem_whilo;
            slot_d.llbit_we    = mem_LLbit_we;
            slot_d.llbit_value = mem_LLbit_value;
            slot_d.valid       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wb_wd          = slot_q.wd;
    assign wb_wreg        = slot_q.wreg;
    assign wb_wdata       = slot_q.wdata;
    assign wb_hi          = slot_q.hi;
    assign wb_lo          = slot_q.lo;
    assign wb_whilo       = slot_q.whilo;
    assign wb_LLbit_we    = slot_q.llbit_we;
    assign wb_LLbit_value = slot_q.llbit_value;
    assign wb_valid       = slot_q.valid;
    assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed testbench for mem_wb with an in-bench expected-slot
// model, a small regfile fed from the wb_* outputs, a per-cycle compare
// process and hand-computed literal expectations.
module tb_mem_wb;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic [4:0]       mem_wd;
    logic             mem_wreg;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_hi;
    logic [31:0]      mem_lo;
    logic             mem_whilo;
    logic             mem_LLbit_we;
    logic             mem_LLbit_value;
    logic [4:0]       wb_wd;
    logic             wb_wreg;
    logic [31:0]      wb_wdata;
    logic [31:0]      wb_hi;
    logic [31:0]      wb_lo;
    logic             wb_whilo;
    logic             wb_LLbit_we;
    logic             wb_LLbit_value;
    logic             wb_valid;
    logic [CNT_W-1:0] retired_cnt;

    int errors = 0;
    int checks = 0;

    mem_wb #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .mem_wd         (mem_wd),
        .mem_wreg       (mem_wreg),
        .mem_wdata      (mem_wdata),
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_whilo      (mem_whilo),
        .mem_LLbit_we   (mem_LLbit_we),
        .mem_LLbit_value(mem_LLbit_value),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_whilo       (wb_whilo),
        .wb_LLbit_we    (wb_LLbit_we),
        .wb_LLbit_value (wb_LLbit_value),
        .wb_valid       (wb_valid),
        .retired_cnt    (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected contents of the WB slot and the number of retirements seen.
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        llwe;
        logic        llval;
        logic        valid;
    } slot_t;

    slot_t m;
    int    m_retired;
    bit    model_ok = 1'b0;
    slot_t empty_slot = '{5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        if (rst) begin
            m         <= empty_slot;
            m_retired <= 0;
            model_ok  <= 1'b1;
        end else begin
            // A committed write to a nonzero register is one retirement.
            if (m.valid && m.wreg && m.wd != 5'd0 && !stall[5])
                m_retired <= m_retired + 1;
            if (flush)
                m <= empty_slot;
            else if (stall[4] && !stall[5])
                m <= empty_slot;
            else if (!stall[4])
                m <= '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
                       mem_LLbit_we, mem_LLbit_value, 1'b1};
        end
    end

    // Register file as seen by the downstream stage; address 0 is discarded.
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    always @(posedge clk) begin
        if (wb_wreg && wb_wd != 5'd0) rf[wb_wd] <= wb_wdata;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("wd",      32'(wb_wd),          32'(m.wd));
            chk("wreg",    32'(wb_wreg),        32'(m.wreg));
            chk("wdata",   wb_wdata,            m.wdata);
            chk("hi",      wb_hi,               m.hi);
            chk("lo",      wb_lo,               m.lo);
            chk("whilo",   32'(wb_whilo),       32'(m.whilo));
            chk("llwe",    32'(wb_LLbit_we),    32'(m.llwe));
            chk("llval",   32'(wb_LLbit_value), 32'(m.llval));
            chk("valid",   32'(wb_valid),       32'(m.valid));
            chk("cnt",     32'(retired_cnt),    32'(m_retired % (1 << CNT_W)));
        end
    end

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [5:0] stl, input logic fl);
        mem_wd          = wd;
        mem_wreg        = wreg;
        mem_wdata       = wdata;
        mem_hi          = wdata ^ 32'hFFFF_0000;
        mem_lo          = ~wdata;
        mem_whilo       = wreg;
        mem_LLbit_we    = wreg;
        mem_LLbit_value = wdata[0];
        stall           = stl;
        flush           = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd7, 1'b1, 32'hAAAA_5555, 6'd0, 1'b0);
        step();
        step();
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_wreg",  32'(wb_wreg),  32'd0);
        chk("rst_wd",    32'(wb_wd),    32'd0);
        chk("rst_wdata", wb_wdata,      32'd0);
        chk("rst_cnt",   32'(retired_cnt), 32'd0);

        // Capture
        rst = 1'b0;
        drive(5'd3, 1'b1, 32'h1234_5678, 6'd0, 1'b0);
        step();
        chk("cap_wd",    32'(wb_wd),    32'd3);
        chk("cap_wdata", wb_wdata,      32'h1234_5678);
        chk("cap_valid", 32'(wb_valid), 32'd1);
        drive(5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        step();
        chk("cap_cnt",   32'(retired_cnt), 32'd1);
        chk("cap_rf3",   rf[3],         32'h1234_5678);

        // MEM held, WB running
        drive(5'd4, 1'b1, 32'h0000_00C4, 6'b010000, 1'b0);
        step();
        chk("hold_wreg",  32'(wb_wreg),  32'd0);
        chk("hold_valid", 32'(wb_valid), 32'd0);
        chk("hold_cnt",   32'(retired_cnt), 32'd1);
        drive(5'd4, 1'b1, 32'h0000_00C4, 6'd0, 1'b0);
        step();
        drive(5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        step();
        chk("hold_once", 32'(retired_cnt), 32'd2);

        // Both held
        drive(5'd5, 1'b1, 32'h5555_0005, 6'd0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(5'd9, 1'b1, 32'h9999_9999, 6'b110000, 1'b0);
            step();
            chk("both_wd",    32'(wb_wd),    32'd5);
            chk("both_wdata", wb_wdata,      32'h5555_0005);
            chk("both_cnt",   32'(retired_cnt), 32'd2);
        end
        drive(5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        step();
        chk("both_rel", 32'(retired_cnt), 32'd3);

        // Flush together with MEM held
        drive(5'd7, 1'b1, 32'h7777_0007, 6'b010000, 1'b1);
        step();
        chk("fl_whilo", 32'(wb_whilo),    32'd0);
        chk("fl_llwe",  32'(wb_LLbit_we), 32'd0);
        chk("fl_wreg",  32'(wb_wreg),     32'd0);
        chk("fl_cnt",   32'(retired_cnt), 32'd3);

        // Zero address write
        drive(5'd0, 1'b1, 32'hDEAD_BEEF, 6'd0, 1'b0);
        step();
        chk("z_wreg", 32'(wb_wreg), 32'd1);
        chk("z_wd",   32'(wb_wd),   32'd0);
        drive(5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        step();
        chk("z_cnt", 32'(retired_cnt), 32'd3);
        chk("z_rf0", rf[0],            32'd0);

        // 16 writes to reg 1 wrap the 4-bit counter to its start value
        for (int i = 0; i < 16; i++) begin
            drive(5'd1, 1'b1, 32'h1000_0000 + 32'(i), 6'd0, 1'b0);
            step();
        end
        drive(5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        step();
        chk("wrap_cnt", 32'(retired_cnt), 32'd3);
        chk("wrap_rf1", rf[1],            32'h1000_000F);

        // Illegal stall encoding captures
        drive(5'd2, 1'b1, 32'h2222_2222, 6'b100000, 1'b0);
        step();
        chk("ill_wd",    32'(wb_wd),    32'd2);
        chk("ill_valid", 32'(wb_valid), 32'd1);

        // Reset mid-stream drops the in-flight result
        drive(5'd9, 1'b1, 32'h9090_9090, 6'd0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("mid_valid", 32'(wb_valid),    32'd0);
        chk("mid_cnt",   32'(retired_cnt), 32'd0);
        rst = 1'b0;
        drive(5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
# mem_wb

MEM/WB pipeline register and the write-side driver of the general register file's write port. Each cycle it captures the memory stage's result (destination address, write enable, write data) plus the HI/LO and LLbit side results. It presents them to the register file write port and to the HI/LO and LLbit units on the following cycle. It applies the pipeline stall/flush policy and keeps a retired-write counter for debug and performance.

## Interface

Parameters:
- CNT_W, 32, width of the retired-write counter.
- Data widths come from `defines.v`: `RegBus` is 32 bits, `RegAddrBus` is 5 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset (`RstEnable` = 1); synchronous, active-high
- stall  in  6  per-stage stop vector; bit 4 = MEM stage held, bit 5 = WB stage held (`Stop` = 1)
- flush  in  1  exception flush; kills the in-flight MEM result
- mem_wd  in  `RegAddrBus`  destination register address
- mem_wreg  in  1  register write enable (`WriteEnable` = 1)
- mem_wdata  in  `RegBus`  register write data
- mem_hi, mem_lo  in  `RegBus` each  HI/LO write data
- mem_whilo  in  1  HI/LO write enable
- mem_LLbit_we  in  1  LLbit write enable
- mem_LLbit_value  in  1  LLbit write value
- wb_wd  out  `RegAddrBus`  to regfile waddr
- wb_wreg  out  1  to regfile we
- wb_wdata  out  `RegBus`  to regfile wdata
- wb_hi, wb_lo  out  `RegBus` each  to HI/LO unit
- wb_whilo  out  1  to HI/LO unit
- wb_LLbit_we, wb_LLbit_value  out  1 each  to LLbit unit
- wb_valid  out  1  registered slot holds a real instruction (not a bubble)
- retired_cnt  out  CNT_W  count of completed register-file writes

## Operation

Per rising edge, conditions are evaluated in priority order:

1. **Reset.** When rst = 1, all outputs are set to 0. This includes wb_wreg = `WriteDisable`, wb_wd = 0, wb_valid = 0 and retired_cnt = 0.
2. **Flush.** When flush = 1, a bubble is inserted: all wb_* outputs go to 0 and wb_valid = 0. retired_cnt is unchanged.
3. **MEM held, WB running.** When stall[4] = 1 and stall[5] = 0, a bubble is inserted (same as flush). This prevents the held instruction being written twice.
4. **MEM running.** When stall[4] = 0, all mem_* inputs are captured into the wb_* outputs and wb_valid = 1.
5. **Otherwise**, both stages are held: all registers, including wb_valid, keep their value.

Retired-write counter:
- retired_cnt increments by 1 on every edge where the currently registered slot has wb_valid = 1, wb_wreg = 1, wb_wd != 0, and the slot is not being held (stall[5] = 0).
- The counter is evaluated on the outgoing value, so each instruction is counted exactly once.
- The counter is unsigned modulo 2^CNT_W: all-ones + 1 wraps to 0, with no saturation and no flag.
- Writes to address 0 are passed to the regfile unchanged (the regfile discards them) but are not counted.

Other rules:
- No transformation of data is performed; the path is a pure register.
- The HI/LO and LLbit fields obey exactly the same capture/bubble/hold rules as the register fields.

## Timing

- Latency: 1 cycle from mem_* to wb_*. The regfile then commits on the next edge.
- Same-cycle regfile read-after-write bypass is provided by the regfile from wb_wd/wb_wdata. This block adds no forwarding.
- flush and rst take effect at the edge where they are sampled. rst dominates flush, and flush dominates stall.
- Reset mid-stream: the in-flight result is lost and the counter restarts at 0 on the next edge.
- Flush and stall[4] asserted together: flush wins and a bubble is inserted.
- stall[4] = 0 with stall[5] = 1 is an illegal encoding from the stall controller. Treat it as capture (rule 4).

## Test plan

1. **Reset.** Hold rst = 1 for 2 cycles with nonzero mem_* inputs -> all outputs read 0; retired_cnt = 0.
2. **Capture.** Drive mem_wd = 5'd3, mem_wreg = 1, mem_wdata = 32'h1234_5678, with stall = 0 -> next cycle wb_wd = 3, wb_wdata = 32'h1234_5678, wb_valid = 1. One cycle later retired_cnt = 1 and regfile reg 3 reads 32'h1234_5678.
3. **MEM held.** Apply stall = 6'b010000 for 1 cycle with a valid write at MEM -> wb_wreg = 0 and wb_valid = 0 that cycle. Then stall = 0 -> the instruction is written once; retired_cnt advances by exactly 1.
4. **Both held.** Apply stall = 6'b110000 for 3 cycles -> wb_* outputs are frozen and retired_cnt is constant. Release -> one increment.
5. **Flush.** Assert flush = 1 together with stall = 6'b010000 while mem_whilo = 1 and mem_LLbit_we = 1 -> wb_whilo = 0, wb_LLbit_we = 0, wb_wreg = 0; retired_cnt is unchanged.
6. **Zero address and wrap.** With CNT_W = 4 and a write with mem_wd = 0 -> wb_wreg = 1, regfile reg 0 still reads 0, and retired_cnt is unchanged. Then 16 valid writes to reg 1 -> retired_cnt wraps back to its starting value.
